hazard_ctrl_sb: RTL

- Parametrised successor hazard controller for the 5-stage pipeline.
- Provides M/W operand forwarding, x0-safe load-use interlock and separate F/D/E stall and flush controls.
- Adds a one-entry scoreboard for the multi-cycle mul/div unit, which launches from E and writes back through W.
- Contains real state: busy flag, destination tag, in-flight cycle counter with watchdog, and optional perf counters.

---
 rtl/hazard_ctrl_sb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: M/W forwarding, load-use interlock, redirect flush and a
// one-entry mul/div scoreboard with watchdog. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl_sb #(
  parameter int AW         = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1D,
  input  logic [AW-1:0] rs2D,
  input  logic [AW-1:0] rdD,
  input  logic          regwriteD,
  input  logic          mdopD,
  input  logic [AW-1:0] rs1E,
  input  logic [AW-1:0] rs2E,
  input  logic [AW-1:0] rdE,
  input  logic          memreadE,
  input  logic          mdstartE,
  input  logic          jumpE,
  input  logic          flagE,
  input  logic [AW-1:0] rdM,
  input  logic          regwriteM,
  input  logic [AW-1:0] rdW,
  input  logic          regwriteW,
  input  logic          md_doneW,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE,
  output logic          md_busy,
  output logic [AW-1:0] md_rd,
  output logic          md_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);

  logic [1:0][AW-1:0] rs_e;
  logic [1:0][1:0]    fwd;

  logic          busy_reg, busy_next;
  logic [AW-1:0] rd_reg, rd_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_reg, timeout_next;

  logic lu, sb, redirect;

  assign rs_e = {rs2E, rs1E};

  // M beats W; x0 is never forwarded
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (rs_e[gi] != '0 && regwriteM && rs_e[gi] == rdM) ? 2'b10 :
                       (rs_e[gi] != '0 && regwriteW && rs_e[gi] == rdW) ? 2'b01 : 2'b00;
    end
  endgenerate

  assign forwardaE = fwd[0];
  assign forwardbE = fwd[1];

  assign lu = memreadE && (rdE != '0) && (rdE == rs1D || rdE == rs2D);

  // done cycle releases immediately: the write-first regfile hands D the new value
  assign sb = busy_reg && !md_doneW &&
              (mdopD ||
               ((rd_reg != '0) &&
                (rs1D == rd_reg || rs2D == rd_reg || (regwriteD && rdD == rd_reg))));

  assign redirect = jumpE || flagE;

  assign stallF = (lu || sb) && !redirect;
  assign stallD = stallF;
  assign flushD = redirect;
  assign flushE = redirect || lu || sb;

  assign md_busy    = busy_reg;
  assign md_rd      = rd_reg;
  assign md_timeout = timeout_reg;

  always_comb begin
    busy_next    = busy_reg;
    rd_next      = rd_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    if (mdstartE) begin
      busy_next = 1'b1;
      rd_next   = rdE;
      cnt_next  = '0;
    end else if (md_doneW) begin
      busy_next = 1'b0;
    end else if (busy_reg) begin
      if (cnt_reg == CW'(MD_TIMEOUT - 1)) begin
        busy_next    = 1'b0;
        timeout_next = 1'b1;
      end else if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg    <= 1'b0;
      rd_reg      <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      busy_reg    <= busy_next;
      rd_reg      <= rd_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stallD && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flushD && flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
